// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: next-PC source encoding,
// fetch state encoding, instruction width and sequential PC step.
package riscv_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Next-PC selection driven by decode/execute on the accept cycle.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_src_t;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_REQ   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } fetch_state_t;

  // A fetch target is legal only when it is word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target computation and alignment handling.
// Build option PC_MISALIGN_TRAP_EN: when defined, a misaligned target is
// replaced by TRAP_VEC and flagged; otherwise the low two bits are cleared
// and the flag stays low.
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  pc_src_t     pc_src,
  input  logic [31:0] instr_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] raw_target_s;
  logic [31:0] jalr_sum_s;

  // JALR base + offset; carry out of bit 31 is intentionally dropped.
  assign jalr_sum_s = rs1 + imm;

  // Raw target selection before any alignment treatment.
  always_comb begin
    raw_target_s = instr_pc + PC_STEP;
    case (pc_src)
      PC_SEQ:    raw_target_s = instr_pc + PC_STEP;
      PC_BRANCH: raw_target_s = instr_pc + imm;
      PC_JAL:    raw_target_s = instr_pc + imm;
      PC_JALR:   raw_target_s = jalr_sum_s & 32'hFFFF_FFFE;
      default:   raw_target_s = instr_pc + PC_STEP;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned targets are redirected to the trap vector.
  always_comb begin
    misaligned = is_misaligned(raw_target_s);
    if (misaligned) begin
      next_pc = TRAP_VEC;
    end else begin
      next_pc = raw_target_s;
    end
  end
`else
  logic unused_trap_vec_s;

  // The trap vector only matters in the trapping build.
  assign unused_trap_vec_s = ^TRAP_VEC;

  // Without trapping, the target is forced onto a word boundary.
  always_comb begin
    misaligned = 1'b0;
    next_pc    = raw_target_s & 32'hFFFF_FFFC;
  end
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage. Issues one word fetch at a
// time over a req/gnt/rvalid handshake, holds the instruction for decode and
// advances the PC when decode accepts it.
// Build option PC_MISALIGN_TRAP_EN selects trap-on-misaligned-target
// behaviour (misalign pulse, redirect to TRAP_VEC); default build aligns.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        imm,
  input  logic [31:0]        rs1,
  output logic               misalign
);

  fetch_state_t       state_r;
  fetch_state_t       state_nxt_s;
  logic               capture_s;
  logic               accept_s;
  logic [31:0]        pc_r;
  logic [31:0]        target_s;
  logic               target_mis_s;
  pc_src_t            pc_src_s;
  logic               imem_req_r;
  logic [31:0]        imem_addr_r;
  logic               instr_valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [31:0]        instr_pc_r;

  assign pc_src_s = pc_src_t'(pc_src);

  next_pc_calc #(
    .TRAP_VEC(TRAP_VEC)
  ) u_next_pc_calc (
    .pc_src    (pc_src_s),
    .instr_pc  (instr_pc_r),
    .imm       (imm),
    .rs1       (rs1),
    .next_pc   (target_s),
    .misaligned(target_mis_s)
  );

  // Fetch sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic plus capture/accept strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_RESET;
      end
    endcase
  end

  // PC and fetch request registers; the address is loaded once per fetch so
  // it cannot move while the memory has not yet granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      imem_req_r  <= 1'b0;
      imem_addr_r <= 32'h0000_0000;
    end else begin
      imem_req_r <= (state_nxt_s == ST_REQ);
      if (accept_s) begin
        pc_r        <= target_s;
        imem_addr_r <= target_s;
      end else if (state_r == ST_RESET) begin
        imem_addr_r <= pc_r;
      end
    end
  end

  // Instruction holding registers presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_r <= 1'b0;
      instr_r       <= {INSTR_W{1'b0}};
      instr_pc_r    <= 32'h0000_0000;
    end else begin
      if (capture_s) begin
        instr_valid_r <= 1'b1;
        instr_r       <= imem_rdata;
        instr_pc_r    <= pc_r;
      end else if (accept_s) begin
        instr_valid_r <= 1'b0;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_r;

  // One-cycle pulse following the accept that produced a misaligned target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= accept_s & target_mis_s;
    end
  end

  assign misalign = misalign_r;
`else
  logic unused_target_mis_s;

  // The aligning build never reports a misaligned target.
  assign unused_target_mis_s = target_mis_s;
  assign misalign            = 1'b0;
`endif

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a memory/decode driver issues fetches
// and accepts, pushing expected addresses/instructions into queues; a
// monitor on the falling edge pops and compares.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        misalign;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];
  logic        exp_mis_q[$];
  logic        mis_pending;
  logic [31:0] model_fetch_addr;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc_src(pc_src), .imm(imm), .rs1(rs1),
    .misalign(misalign)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: expected DUT event did not occur (t=%0t)", name, $time);
  endtask

  // Reference: next fetch address from the architectural rules.
  function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] ipc,
                                             input logic [31:0] im, input logic [31:0] r1,
                                             output logic mis);
    logic [31:0] t;
    if (src == 2'd0) t = ipc + 32'd4;
    else if (src == 2'd3) t = (r1 + im) & 32'hFFFF_FFFE;
    else t = ipc + im;
    mis = 1'b0;
    if (t[1:0] != 2'b00) begin
`ifdef PC_MISALIGN_TRAP_EN
      mis = 1'b1;
      t = TRAP_VEC;
`else
      t = t & 32'hFFFF_FFFC;
`endif
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    instr_ready = 1'b0;
    pc_src      = 2'($urandom_range(0, 3));
    imm         = $urandom;
    rs1         = $urandom;
  endtask

  // One complete fetch: grant after gd cycles, data lat cycles after grant,
  // accept rd cycles after the instruction becomes valid.
  task automatic run_txn(input int gd, input int lat, input int rd,
                         input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1);
    int          waited;
    logic [31:0] data;
    logic [31:0] nxt;
    logic        m;
    waited = 0;
    while (!imem_req && waited < 50) begin
      idle_inputs();
      tick();
      waited++;
    end
    if (!imem_req) begin
      fail_now("req_timeout");
      return;
    end
    for (int i = 0; i < gd; i++) begin
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, model_fetch_addr);
      idle_inputs();
      imem_rvalid = 1'($urandom_range(0, 1));
      tick();
    end
    data = $urandom;
    idle_inputs();
    imem_gnt = 1'b1;
    if (lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      exp_instr_q.push_back({model_fetch_addr, data});
    end
    tick();
    for (int i = 1; i <= lat; i++) begin
      idle_inputs();
      check("req_low_wait", {31'd0, imem_req}, 32'd0);
      if (i == lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        exp_instr_q.push_back({model_fetch_addr, data});
      end
      tick();
    end
    check("valid_after_capture", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < rd; i++) begin
      idle_inputs();
      imem_rvalid = 1'($urandom_range(0, 1));
      tick();
      check("req_low_hold", {31'd0, imem_req}, 32'd0);
    end
    idle_inputs();
    imem_rvalid = 1'($urandom_range(0, 1));
    instr_ready = 1'b1;
    pc_src      = src;
    imm         = im;
    rs1         = r1;
    nxt = model_next(src, model_fetch_addr, im, r1, m);
    exp_addr_q.push_back(nxt);
    exp_mis_q.push_back(m);
    model_fetch_addr = nxt;
    tick();
    check("req_after_accept", {31'd0, imem_req}, 32'd1);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  initial begin
    logic [63:0] e;
    mis_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("misalign", {31'd0, misalign}, {31'd0, mis_pending});
        if (imem_req && imem_gnt) begin
          if (exp_addr_q.size() == 0) fail_now("addr_unexpected");
          else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (instr_valid) begin
          if (exp_instr_q.size() == 0) fail_now("instr_unexpected");
          else begin
            e = exp_instr_q[0];
            check("instr", instr, e[31:0]);
            check("instr_pc", instr_pc, e[63:32]);
            if (instr_ready) void'(exp_instr_q.pop_front());
          end
        end
        if (instr_valid && instr_ready && exp_mis_q.size() != 0) mis_pending = exp_mis_q.pop_front();
        else mis_pending = 1'b0;
      end else begin
        mis_pending = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    int waited;
    logic [31:0] im;
    idle_inputs();
    model_fetch_addr = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);

    // Directed walk through the interesting targets.
    run_txn(0, 0, 0, 2'd0, 32'h0, 32'h0);                 // 0x0 -> 0x4
    run_txn(0, 0, 0, 2'd0, 32'h0, 32'h0);                 // 0x4 -> 0x8
    run_txn(0, 0, 0, 2'd2, 32'h18, 32'h0);                // 0x8 -> 0x20
    run_txn(2, 3, 2, 2'd1, 32'hFFFF_FFF0, 32'h0);         // 0x20 -> 0x10
    run_txn(0, 1, 0, 2'd3, 32'h4, 32'hFFFF_FFF8);         // 0x10 -> 0xFFFFFFFC
    run_txn(0, 0, 0, 2'd0, 32'h0, 32'h0);                 // wrap -> 0x0
    run_txn(1, 0, 1, 2'd3, 32'h4, 32'h0000_1001);         // -> 0x1004
    run_txn(0, 2, 0, 2'd2, 32'hFFFF_F03C, 32'h0);         // -> 0x40
    run_txn(0, 0, 0, 2'd2, 32'h2, 32'h0);                 // misaligned
    run_txn(0, 0, 0, 2'd0, 32'h0, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 0) im = ($urandom & 32'h0000_00FF) - 32'h0000_0080;
      else im = $urandom;
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
              2'($urandom_range(0, 3)), im, $urandom);
    end

    // Reset asserted while waiting for read data.
    waited = 0;
    while (!imem_req && waited < 50) begin
      idle_inputs();
      tick();
      waited++;
    end
    if (!imem_req) fail_now("req_timeout_rst");
    idle_inputs();
    imem_gnt = 1'b1;
    tick();
    idle_inputs();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'd0, imem_req}, 32'd0);
    check("abort_addr", imem_addr, 32'd0);
    check("abort_valid", {31'd0, instr_valid}, 32'd0);
    check("abort_instr", instr, 32'd0);
    check("abort_instr_pc", instr_pc, 32'd0);
    check("abort_misalign", {31'd0, misalign}, 32'd0);
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_mis_q.delete();
    model_fetch_addr = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD1_BAD1;
    tick();
    check("stale_ignored_valid", {31'd0, instr_valid}, 32'd0);
    run_txn(0, 0, 0, 2'd0, 32'h0, 32'h0);
    run_txn(0, 2, 1, 2'd0, 32'h0, 32'h0);
    idle_inputs();
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle RISC-V core. Holds the PC, fetches one 32-bit instruction at a time over a request/grant/valid instruction-memory handshake, and presents it to decode, where bits [31:7] feed `immediate_generator`. On each instruction accepted by decode, computes the next PC from the sign-extended immediate returned by `immediate_generator` (branch, JAL, JALR) or PC+4.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `TRAP_VEC`, 32'h0000_0100: redirect address on misaligned target (only with `PC_MISALIGN_TRAP_EN`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word-aligned.
- `imem_gnt` in 1: memory accepted request.
- `imem_rvalid` in 1: `imem_rdata` valid.
- `imem_rdata` in 32: fetched instruction.
- `instr_valid` out 1: `instr`/`instr_pc` valid for decode.
- `instr` out 32: held instruction; [31:7] goes to `immediate_generator.immediate`.
- `instr_pc` out 32: address of `instr`.
- `instr_ready` in 1: decode/execute consumes instruction this cycle.
- `pc_src` in 2: 00 seq (PC+4), 01 branch taken, 10 JAL, 11 JALR.
- `imm` in 32: sign-extended immediate from `immediate_generator.out`.
- `rs1` in 32: register operand for JALR.
- `misalign` out 1: one-cycle pulse, misaligned target detected.

## Operation
- States: RESET -> REQ -> WAIT -> HOLD -> REQ.
- RESET: entered asynchronously on `rst_n`=0; all outputs 0, `pc`=RESET_PC; leaves unconditionally to REQ on first clock after release.
- REQ: `imem_req`=1, `imem_addr`=`pc`, held stable until `imem_gnt`. gnt without rvalid -> WAIT; gnt with rvalid same cycle -> capture, HOLD.
- WAIT: `imem_req`=0; on `imem_rvalid` capture `imem_rdata` into `instr`, `instr_pc`=`pc`, -> HOLD.
- HOLD: `instr_valid`=1, `instr`/`instr_pc` stable. On `instr_ready`: `pc`<=next_pc, -> REQ.
- next_pc: 00 -> `instr_pc`+4; 01/10 -> `instr_pc`+`imm`; 11 -> (`rs1`+`imm`) & ~32'h1. All adds 32-bit, wrap modulo 2^32, carry discarded.
- `pc_src`, `imm`, `rs1` sampled only on the HOLD&`instr_ready` cycle; ignored otherwise.
- `imem_rvalid` outside WAIT/REQ-with-gnt ignored (covers stale responses after reset).
- Misaligned target: next_pc[1:0]!=0 (handled per Configuration).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign`=0.
- First `imem_req` in cycle 1 after `rst_n` release, address RESET_PC.
- Zero-wait memory (gnt+rvalid same cycle): 2 cycles per instruction (REQ, HOLD with ready=1).
- N-cycle rvalid latency: 2+N cycles per instruction.
- `instr_valid` rises the cycle after capture; `imem_req` rises the cycle after accept.
- `misalign` asserted the cycle after the accept that produced the bad target.
- `rst_n` low mid-fetch: immediate abort to RESET, outputs zero same instant.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: misaligned next_pc -> `pc`<=TRAP_VEC, `misalign` pulses 1 cycle.
- Undefined: next_pc[1:0] forced to 00, `misalign` tied 0, TRAP_VEC unused.

## Structure
- Shared package `riscv_pkg`: `pc_src_t` enum (PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR), fetch state enum, `INSTR_W`=32, `PC_STEP`=4.
- Sub-module `next_pc_calc`: combinational target computation and alignment check; FSM and registers stay in `pc_fetch_unit`.

## Test plan
- Reset release, zero-wait memory, ready=1, pc_src=00 -> addrs 0x0,0x4,0x8; one instruction every 2 cycles.
- rvalid 3 cycles after gnt, instr_ready held 0 two cycles -> `instr` stable through HOLD, `imem_req` low until accept, `imem_addr` stable while waiting for gnt.
- instr_pc=0x20, pc_src=01, imm=32'hFFFF_FFF0 -> next fetch 0x10; pc=0xFFFF_FFFC, pc_src=00 -> wraps to 0x0.
- pc_src=11, rs1=0x1001, imm=0x4 -> next fetch 0x1004 (bit0 cleared).
- JAL imm=0x2 from 0x40: with `PC_MISALIGN_TRAP_EN` -> `misalign` pulse, fetch 0x100; without -> fetch 0x40.
- `rst_n` low during WAIT, late rvalid after release -> outputs zero, stale data ignored, fetch restarts at RESET_PC.
